// File: rtl/exc_ctrl_pkg.sv
// Shared CP0 header for the exception controller: vectors, exception codes,
// commit_exc bit positions and the controller state encoding.
package exc_ctrl_pkg;

    localparam logic [31:0] CP0_VEC_BEV1 = 32'hBFC00380;
    localparam logic [31:0] CP0_VEC_BEV0 = 32'h80000180;

    localparam int EXC_W = 7;

    localparam int EXC_BIT_ADEL_IF = 0;
    localparam int EXC_BIT_RI      = 1;
    localparam int EXC_BIT_OV      = 2;
    localparam int EXC_BIT_SYS     = 3;
    localparam int EXC_BIT_BP      = 4;
    localparam int EXC_BIT_ADEL_D  = 5;
    localparam int EXC_BIT_ADES    = 6;

    localparam logic [4:0] EXCODE_INT  = 5'h00;
    localparam logic [4:0] EXCODE_ADEL = 5'h04;
    localparam logic [4:0] EXCODE_ADES = 5'h05;
    localparam logic [4:0] EXCODE_SYS  = 5'h08;
    localparam logic [4:0] EXCODE_BP   = 5'h09;
    localparam logic [4:0] EXCODE_RI   = 5'h0a;
    localparam logic [4:0] EXCODE_OV   = 5'h0c;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        BADV_NONE = 2'd0,
        BADV_PC   = 2'd1,
        BADV_DATA = 2'd2
    } badv_sel_t;

endpackage

// File: rtl/exc_ctrl_prio.sv
// Fixed-priority encoder: interrupt, then commit_exc bits in architectural
// order, then ERET; yields excode, ERET-wins flag and BadVAddr source.
module exc_prio
    import exc_ctrl_pkg::*;
(
    input  logic             i_int_req,
    input  logic [EXC_W-1:0] i_exc,
    input  logic             i_eret,
    output logic             o_event,
    output logic             o_is_int,
    output logic             o_eret_win,
    output logic [4:0]       o_excode,
    output badv_sel_t        o_badv_sel
);

    always_comb begin
        o_event    = i_int_req | (|i_exc) | i_eret;
        o_is_int   = i_int_req;
        o_eret_win = 1'b0;
        o_excode   = EXCODE_INT;
        o_badv_sel = BADV_NONE;
        if (i_int_req) begin
            o_excode = EXCODE_INT;
        end else if (i_exc[EXC_BIT_ADEL_IF]) begin
            o_excode   = EXCODE_ADEL;
            o_badv_sel = BADV_PC;
        end else if (i_exc[EXC_BIT_RI]) begin
            o_excode = EXCODE_RI;
        end else if (i_exc[EXC_BIT_OV]) begin
            o_excode = EXCODE_OV;
        end else if (i_exc[EXC_BIT_SYS]) begin
            o_excode = EXCODE_SYS;
        end else if (i_exc[EXC_BIT_BP]) begin
            o_excode = EXCODE_BP;
        end else if (i_exc[EXC_BIT_ADEL_D]) begin
            o_excode   = EXCODE_ADEL;
            o_badv_sel = BADV_DATA;
        end else if (i_exc[EXC_BIT_ADES]) begin
            o_excode   = EXCODE_ADES;
            o_badv_sel = BADV_DATA;
        end else if (i_eret) begin
            o_eret_win = 1'b1;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Commit-stage exception/ERET controller: reports to CP0, flushes, then
// redirects fetch. Optional statistics counters under EXC_CTRL_STAT_EN.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] VEC_BEV1 = CP0_VEC_BEV1,
    parameter logic [31:0] VEC_BEV0 = CP0_VEC_BEV0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             commit_valid,
    output logic             commit_ready,
    input  logic [31:0]      commit_pc,
    input  logic             commit_bd,
    input  logic [EXC_W-1:0] commit_exc,
    input  logic [31:0]      commit_badvaddr,
    input  logic             commit_eret,
    input  logic             int_req,
    input  logic             status_bev,
    input  logic [31:0]      cp0_epc,
    output logic             exc_valid,
    output logic             exc_eret,
    output logic             exc_bd,
    output logic [4:0]       exc_excode,
    output logic [31:0]      exc_epc,
    output logic [31:0]      exc_badvaddr,
    output logic             flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
`ifdef EXC_CTRL_STAT_EN
    output logic [31:0]      stat_exc_cnt,
    output logic [31:0]      stat_int_cnt,
`endif
    input  logic             redirect_ready
);

    state_t     r_state, w_next;
    logic [4:0] r_excode;
    logic       r_eret, r_bd, r_int;
    logic [31:0] r_epc, r_badvaddr, r_target;

    logic       w_event, w_is_int, w_eret_win, w_take;
    logic [4:0] w_excode;
    badv_sel_t  w_badv_sel;
    logic [31:0] w_badvaddr;

    exc_prio u_prio (
        .i_int_req  (int_req),
        .i_exc      (commit_exc),
        .i_eret     (commit_eret),
        .o_event    (w_event),
        .o_is_int   (w_is_int),
        .o_eret_win (w_eret_win),
        .o_excode   (w_excode),
        .o_badv_sel (w_badv_sel)
    );

    // Only an event-carrying accept in IDLE changes anything.
    assign w_take = (r_state == ST_IDLE) & commit_valid & w_event;

    always_comb begin
        case (w_badv_sel)
            BADV_PC:   w_badvaddr = commit_pc;
            BADV_DATA: w_badvaddr = commit_badvaddr;
            default:   w_badvaddr = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        commit_ready   = 1'b0;
        exc_valid      = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                commit_ready = 1'b1;
                if (w_take) w_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                exc_valid = 1'b1;
                flush     = 1'b1;
                w_next    = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                redirect_valid = 1'b1;
                if (redirect_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_excode   <= 5'd0;
            r_eret     <= 1'b0;
            r_bd       <= 1'b0;
            r_int      <= 1'b0;
            r_epc      <= 32'd0;
            r_badvaddr <= 32'd0;
            r_target   <= 32'd0;
        end else if (w_take) begin
            r_excode   <= w_excode;
            r_eret     <= w_eret_win;
            r_bd       <= commit_bd;
            r_int      <= w_is_int;
            r_epc      <= commit_bd ? (commit_pc - 32'd4) : commit_pc;
            r_badvaddr <= w_badvaddr;
            r_target   <= w_eret_win ? cp0_epc : (status_bev ? VEC_BEV1 : VEC_BEV0);
        end
    end

    assign exc_excode   = r_excode;
    assign exc_eret     = r_eret;
    assign exc_bd       = r_bd;
    assign exc_epc      = r_epc;
    assign exc_badvaddr = r_badvaddr;
    assign redirect_pc  = r_target;

`ifdef EXC_CTRL_STAT_EN
    logic [31:0] r_stat_exc, r_stat_int;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_exc <= 32'd0;
            r_stat_int <= 32'd0;
        end else if (r_state == ST_FLUSH && !r_eret) begin
            if (r_int) r_stat_int <= r_stat_int + 32'd1;
            else       r_stat_exc <= r_stat_exc + 32'd1;
        end
    end

    assign stat_exc_cnt = r_stat_exc;
    assign stat_int_cnt = r_stat_int;
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
// Testbench for exc_ctrl: directed cases plus randomized commits checked
// against a rule-level reference model of the exception controller.
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        commit_valid, commit_ready;
    logic [31:0] commit_pc, commit_badvaddr, cp0_epc;
    logic        commit_bd, commit_eret, int_req, status_bev;
    logic [6:0]  commit_exc;
    logic        exc_valid, exc_eret, exc_bd, flush;
    logic [4:0]  exc_excode;
    logic [31:0] exc_epc, exc_badvaddr;
    logic        redirect_valid, redirect_ready;
    logic [31:0] redirect_pc;
`ifdef EXC_CTRL_STAT_EN
    logic [31:0] stat_exc_cnt, stat_int_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int exp_exc_cnt = 0;
    int exp_int_cnt = 0;

    always #5 clk = ~clk;

    exc_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .commit_valid    (commit_valid),
        .commit_ready    (commit_ready),
        .commit_pc       (commit_pc),
        .commit_bd       (commit_bd),
        .commit_exc      (commit_exc),
        .commit_badvaddr (commit_badvaddr),
        .commit_eret     (commit_eret),
        .int_req         (int_req),
        .status_bev      (status_bev),
        .cp0_epc         (cp0_epc),
        .exc_valid       (exc_valid),
        .exc_eret        (exc_eret),
        .exc_bd          (exc_bd),
        .exc_excode      (exc_excode),
        .exc_epc         (exc_epc),
        .exc_badvaddr    (exc_badvaddr),
        .flush           (flush),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
`ifdef EXC_CTRL_STAT_EN
        .stat_exc_cnt    (stat_exc_cnt),
        .stat_int_cnt    (stat_int_cnt),
`endif
        .redirect_ready  (redirect_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: the architectural rules, scanned as a priority list.
    task automatic model(input logic [31:0] pc, input logic bd, input logic [6:0] exc,
                         input logic [31:0] badv, input logic eret, input logic intr,
                         input logic bev, input logic [31:0] epc_in,
                         output logic [4:0] code, output logic eret_o,
                         output logic [31:0] bv, output logic [31:0] tgt,
                         output logic [31:0] epc_o);
        int codes [7] = '{4, 10, 12, 8, 9, 4, 5};
        bit found = 0;
        code   = 5'd0;
        eret_o = 1'b0;
        bv     = 32'd0;
        tgt    = bev ? 32'hBFC00380 : 32'h80000180;
        epc_o  = pc - (bd ? 32'd4 : 32'd0);
        if (!intr) begin
            for (int i = 0; i < 7; i++) begin
                if (!found && exc[i]) begin
                    found = 1;
                    code  = 5'(codes[i]);
                    if (i == 0)      bv = pc;
                    else if (i >= 5) bv = badv;
                end
            end
            if (!found && eret) begin
                eret_o = 1'b1;
                tgt    = epc_in;
            end
        end
    endtask

    task automatic go_quiet();
        commit_valid   = 1'b0;
        commit_exc     = 7'd0;
        commit_eret    = 1'b0;
        int_req        = 1'b0;
        redirect_ready = 1'b0;
    endtask

    task automatic scramble();
        logic [31:0] r;
        r = $urandom;
        commit_valid    = r[0];
        commit_exc      = r[7:1];
        commit_eret     = r[8];
        int_req         = r[9];
        status_bev      = r[10];
        commit_bd       = r[11];
        redirect_ready  = r[12];
        commit_pc       = $urandom;
        commit_badvaddr = $urandom;
        cp0_epc         = $urandom;
    endtask

    // Called at a negedge in IDLE; returns at a negedge back in IDLE.
    task automatic run_event(input logic [31:0] pc, input logic bd, input logic [6:0] exc,
                             input logic [31:0] badv, input logic eret, input logic intr,
                             input logic bev, input logic [31:0] epc_in, input int hold);
        logic [4:0]  e_code;
        logic        e_eret;
        logic [31:0] e_bv, e_tgt, e_epc;
        model(pc, bd, exc, badv, eret, intr, bev, epc_in, e_code, e_eret, e_bv, e_tgt, e_epc);
        if (!e_eret) begin
            if (intr) exp_int_cnt++;
            else      exp_exc_cnt++;
        end
        chk("ready_before_event", commit_ready, 1);
        commit_valid = 1'b1; commit_pc = pc; commit_bd = bd; commit_exc = exc;
        commit_badvaddr = badv; commit_eret = eret; int_req = intr;
        status_bev = bev; cp0_epc = epc_in;
        @(posedge clk); @(negedge clk);
        chk("exc_valid", exc_valid, 1);
        chk("flush", flush, 1);
        chk("ready_in_flush", commit_ready, 0);
        chk("redir_in_flush", redirect_valid, 0);
        chk("excode", exc_excode, e_code);
        chk("exc_eret", exc_eret, e_eret);
        chk("exc_bd", exc_bd, bd);
        chk("exc_epc", exc_epc, e_epc);
        chk("badvaddr", exc_badvaddr, e_bv);
        scramble();
        @(posedge clk); @(negedge clk);
        chk("exc_valid_pulse", exc_valid, 0);
        chk("flush_pulse", flush, 0);
        chk("redir_valid", redirect_valid, 1);
        chk("redir_pc", redirect_pc, e_tgt);
        scramble();
        redirect_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); @(negedge clk);
            chk("redir_hold_valid", redirect_valid, 1);
            chk("redir_hold_pc", redirect_pc, e_tgt);
            chk("ready_in_redir", commit_ready, 0);
            chk("exc_valid_hold", exc_valid, 0);
            scramble();
            redirect_ready = 1'b0;
        end
        redirect_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("redir_done", redirect_valid, 0);
        chk("ready_after", commit_ready, 1);
        go_quiet();
    endtask

    task automatic run_plain_accept();
        logic [31:0] r;
        r = $urandom;
        commit_valid = 1'b1; commit_exc = 7'd0; commit_eret = 1'b0; int_req = 1'b0;
        commit_pc = $urandom; commit_bd = r[0]; redirect_ready = r[1]; status_bev = r[2];
        @(posedge clk); @(negedge clk);
        chk("plain_no_exc", exc_valid, 0);
        chk("plain_no_flush", flush, 0);
        chk("plain_no_redir", redirect_valid, 0);
        chk("plain_ready", commit_ready, 1);
        go_quiet();
    endtask

    initial begin
        reset = 1'b1;
        go_quiet();
        commit_pc = 0; commit_bd = 0; commit_badvaddr = 0; status_bev = 0; cp0_epc = 0;
        repeat (2) @(negedge clk);
        chk("rst_exc_valid", exc_valid, 0);
        chk("rst_flush", flush, 0);
        chk("rst_redir", redirect_valid, 0);
        chk("rst_redir_pc", redirect_pc, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", commit_ready, 1);

        // Ov, no delay slot, BEV=1
        run_event(32'h80001000, 0, 7'b0000100, 32'h0, 0, 0, 1, 32'h0, 0);
        // Sys + AdES in a delay slot
        run_event(32'h80002004, 1, 7'b1001000, 32'h12345678, 0, 0, 0, 32'h0, 1);
        // Interrupt beats ERET
        run_event(32'h80004000, 0, 7'd0, 32'h0, 1, 1, 0, 32'h80003000, 0);
        // ERET alone, fetch stalls the redirect for 5 cycles
        run_event(32'h80005000, 0, 7'd0, 32'h0, 1, 0, 1, 32'h80003000, 5);
        // AdEL fetch / AdEL data / delay slot at pc 0 wraps
        run_event(32'h00000000, 1, 7'b0000001, 32'hDEAD0000, 0, 0, 1, 32'h0, 0);
        run_event(32'h80006000, 0, 7'b0100000, 32'hCAFE0001, 0, 0, 0, 32'h0, 0);
        run_plain_accept();

        // Reset while a redirect is pending
        chk("pre_rst_ready", commit_ready, 1);
        commit_valid = 1'b1; commit_eret = 1'b1; cp0_epc = 32'h80003000;
        @(posedge clk); @(negedge clk);
        go_quiet();
        @(posedge clk); @(negedge clk);
        chk("pre_rst_redir", redirect_valid, 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_redir_valid", redirect_valid, 0);
        chk("rst_mid_exc_valid", exc_valid, 0);
        chk("rst_mid_flush", flush, 0);
        chk("rst_mid_redir_pc", redirect_pc, 0);
        @(negedge clk);
        reset = 1'b0;
        redirect_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            chk("post_rst_ready", commit_ready, 1);
            chk("post_rst_no_redir", redirect_valid, 0);
            chk("post_rst_no_exc", exc_valid, 0);
        end
        go_quiet();
`ifdef EXC_CTRL_STAT_EN
        exp_exc_cnt = 0;
        exp_int_cnt = 0;
`endif

        for (int it = 0; it < 40; it++) begin
            logic [31:0] r;
            logic [6:0]  ex;
            logic        er, ir;
            r = $urandom;
            if (r[1:0] == 2'd0) begin
                run_plain_accept();
            end else begin
                ex = (r[3:2] == 2'd0) ? 7'($urandom) : 7'd0;
                if (r[4]) ex = 7'(1 << $urandom_range(0, 6));
                ir = (r[7:5] == 3'd0);
                er = r[8];
                if (ex == 7'd0 && !ir && !er) er = 1'b1;
                run_event($urandom, r[9], ex, $urandom, er, ir, r[10], $urandom,
                          int'($urandom_range(0, 3)));
            end
        end

`ifdef EXC_CTRL_STAT_EN
        chk("stat_exc_cnt", stat_exc_cnt, 32'(exp_exc_cnt));
        chk("stat_int_cnt", stat_int_cnt, 32'(exp_int_cnt));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 Parameter VEC_BEV1, default 32'hBFC00380, exception entry address when status_bev=1.
REQ-002 Parameter VEC_BEV0, default 32'h80000180, exception entry address when status_bev=0.
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 commit_valid  in  1  instruction presented at commit. commit_ready  out  1  controller accepts commit.
REQ-006 commit_pc  in  32  committing PC. commit_bd  in  1  instruction sits in a branch delay slot.
REQ-007 commit_exc  in  7  pending exceptions: bit0 AdEL-fetch, 1 RI, 2 Ov, 3 Sys, 4 Bp, 5 AdEL-data, 6 AdES.
REQ-008 commit_badvaddr  in  32  data address for bits 5/6. commit_eret  in  1  instruction is ERET.
REQ-009 int_req  in  1  CP0 ext_int_response. status_bev  in  1  Status.BEV. cp0_epc  in  32  current EPC.
REQ-010 exc_valid, exc_eret, exc_bd  out  1 each; exc_excode  out  5; exc_epc, exc_badvaddr  out  32 each (CP0 exception port).
REQ-011 flush  out  1  kill all younger in-flight instructions.
REQ-012 redirect_valid  out  1; redirect_pc  out  32; redirect_ready  in  1  fetch redirect handshake.

Function
REQ-013 FSM states IDLE, FLUSH, REDIRECT; commit_ready SHALL be 1 only in IDLE.
REQ-014 Accept = commit_valid & commit_ready; accept with int_req, any commit_exc bit, or commit_eret is an event; otherwise no state change.
REQ-015 Priority fixed: Int(0x00) > AdEL-fetch(0x04) > RI(0x0a) > Ov(0x0c) > Sys(0x08) > Bp(0x09) > AdEL-data(0x04) > AdES(0x05) > ERET.
REQ-016 Event at cycle N: at N+1 exc_valid=1 and flush=1 for exactly one cycle, state FLUSH; fields registered from cycle N.
REQ-017 exc_epc = commit_bd ? commit_pc-32'd4 : commit_pc (mod 2^32); exc_bd = commit_bd.
REQ-018 exc_badvaddr = commit_pc for AdEL-fetch, commit_badvaddr for AdEL-data/AdES, 0 otherwise.
REQ-019 ERET winning: exc_eret=1, exc_excode=0, target = cp0_epc sampled at N; any exception or Int beats ERET.
REQ-020 Exception target = status_bev sampled at N ? VEC_BEV1 : VEC_BEV0; independent of Status.EXL.
REQ-021 FLUSH -> REDIRECT unconditionally after one cycle; redirect_valid=1 with redirect_pc stable until redirect_ready=1; that cycle -> IDLE.
REQ-022 redirect_ready while redirect_valid=0 SHALL be ignored; int_req outside IDLE SHALL be ignored (re-sampled at next accept).
REQ-023 Event-free accept in IDLE SHALL produce no output pulse; back-to-back events separated by at least 3 cycles.

Reset
REQ-024 reset forces IDLE immediately, including mid-FLUSH or mid-REDIRECT; all outputs 0 except commit_ready=1 after release.
REQ-025 A pending redirect aborted by reset SHALL NOT be reissued.

Configuration
REQ-026 Macro EXC_CTRL_STAT_EN: when defined, outputs stat_exc_cnt (32) and stat_int_cnt (32) count exceptions and interrupts at exc_valid pulses, ERET excluded, wrap at 2^32, reset 0.
REQ-027 Without EXC_CTRL_STAT_EN those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-028 Exception codes, commit_exc bit indices and state encoding SHALL live in the shared header alongside the CP0 constants.
REQ-029 One sub-module exc_prio: combinational priority encoder from {int_req, commit_exc, commit_eret} to excode/eret/badvaddr-select.

Verification
REQ-030 Ov at pc=0x80001000, bd=0, bev=1 -> N+1 exc_valid, excode 0x0c, epc 0x80001000, flush; N+2 redirect_pc 0xBFC00380.
REQ-031 Sys+AdES together, bd=1, pc=0x80002004 -> excode 0x08, exc_bd=1, epc 0x80002000, badvaddr 0.
REQ-032 ERET with int_req=1, cp0_epc=0x80003000, bev=0 -> excode 0x00, exc_eret=0, redirect 0x80000180.
REQ-033 ERET alone, cp0_epc=0x80003000 -> exc_eret=1, redirect_pc 0x80003000; redirect_ready held 0 for 5 cycles -> redirect_valid/pc stable, commit_ready=0.
REQ-034 reset asserted in REDIRECT -> outputs 0 same cycle; after release commit_ready=1, no redirect.
REQ-035 With EXC_CTRL_STAT_EN: 3 exceptions + 1 interrupt + 1 ERET -> stat_exc_cnt=3, stat_int_cnt=1.
